// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the branch predictor: 2-bit counter
// encodings and the state written when a new BTB entry is allocated.
package branch_predict_ctrl_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  function automatic logic ctr_predicts_taken(input ctr_t c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_sat_ctr2.sv
// Combinational next-state for a 2-bit saturating up/down counter.
module sat_ctr2
  import branch_predict_ctrl_pkg::*;
(
  input  ctr_t cur,
  input  logic up,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    unique case (cur)
      SNT: nxt = up ? WNT : SNT;
      WNT: nxt = up ? WT  : SNT;
      WT:  nxt = up ? ST  : WNT;
      ST:  nxt = up ? ST  : WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit counters, EX-stage branch resolution,
// redirect/flush generation and branch/mispredict statistics.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_branch,
  input  logic             ex_stall,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = 30 - IDX_BITS;

  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  ctr_t               btb_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit;
  logic                resolve, mispredict;
  ctr_t                ctr_next;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];

  // Lookup reads the array directly, so a same-cycle write is not visible.
  assign if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_predicts_taken(btb_ctr[if_idx]);
  assign pred_target = if_hit ? btb_target[if_idx] : (if_pc + 32'd4);

  assign ex_hit     = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
  assign resolve    = ex_branch && !ex_stall;
  assign mispredict = resolve &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_pred_target != ex_target)));

  // Gated by rst_n so a resolve coinciding with reset assertion never redirects.
  assign redirect    = rst_n && mispredict;
  assign redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
  assign flush_if_id = redirect;
  assign flush_id_ex = redirect;

  sat_ctr2 u_sat_ctr2 (
    .cur (btb_ctr[ex_idx]),
    .up  (ex_taken),
    .nxt (ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid        <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= CTR_RESET;
      end
    end else if (resolve) begin
      branch_count <= branch_count + CNT_W'(1);
      if (mispredict) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
      if (ex_hit) begin
        btb_ctr[ex_idx] <= ctr_next;
        if (ex_taken) begin
          btb_target[ex_idx] <= ex_target;
        end
      end else if (ex_taken) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= ex_target;
        btb_ctr[ex_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: lookup, resolution, counter
// saturation, aliasing, stall handling and reset during a resolve.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_branch, ex_stall, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        redirect, flush_if_id, flush_id_ex;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_predict_ctrl #(.IDX_BITS(4), .CNT_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_branch        (ex_branch),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic branch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    ex_branch      = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic idle();
    ex_branch = 1'b0;
    ex_stall  = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    chk({tag, "_pt"}, {31'd0, pred_taken}, {31'd0, tk});
    chk({tag, "_ptgt"}, pred_target, tgt);
  endtask

  task automatic counts(input string tag, input int b, input int m);
    chk({tag, "_bcnt"}, branch_count, b);
    chk({tag, "_mcnt"}, mispredict_count, m);
  endtask

  task automatic redir(input string tag, input logic r, input logic [31:0] rpc);
    #1;
    chk({tag, "_redir"}, {31'd0, redirect}, {31'd0, r});
    chk({tag, "_fifid"}, {31'd0, flush_if_id}, {31'd0, r});
    chk({tag, "_fidex"}, {31'd0, flush_id_ex}, {31'd0, r});
    if (r) chk({tag, "_rpc"}, redirect_pc, rpc);
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc = 32'h100;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0;
    ex_taken = 1'b0; ex_pred_taken = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    lookup("rst", 32'h100, 1'b0, 32'h104);
    counts("rst", 0, 0);
    redir("rst", 1'b0, 32'h0);
    rst_n = 1'b1;

    // First resolve: taken, predicted not-taken, allocates WT.
    @(negedge clk);
    branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    redir("alloc", 1'b1, 32'h80);
    lookup("nobypass", 32'h100, 1'b0, 32'h104);
    @(negedge clk); idle();
    lookup("alloc", 32'h100, 1'b1, 32'h80);
    counts("alloc", 1, 1);
    redir("idle", 1'b0, 32'h0);

    // Two correct taken predictions -> ST.
    repeat (2) begin
      @(negedge clk);
      branch(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      redir("correct", 1'b0, 32'h0);
    end
    @(negedge clk);
    branch(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    redir("nt1", 1'b1, 32'h104);
    @(negedge clk); idle();
    lookup("st2wt", 32'h100, 1'b1, 32'h80);
    counts("st2wt", 4, 2);

    // Walk down to SNT and check it saturates.
    @(negedge clk);
    branch(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    redir("nt2", 1'b1, 32'h104);
    @(negedge clk); idle();
    lookup("wnt", 32'h100, 1'b0, 32'h80);
    repeat (2) begin
      @(negedge clk);
      branch(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
      redir("nt_ok", 1'b0, 32'h0);
      @(negedge clk); idle();
      lookup("snt", 32'h100, 1'b0, 32'h80);
    end
    @(negedge clk);
    branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    redir("up1", 1'b1, 32'h80);
    @(negedge clk); idle();
    lookup("snt2wnt", 32'h100, 1'b0, 32'h80);
    counts("snt2wnt", 8, 4);

    // Direction right but target wrong still redirects.
    @(negedge clk);
    branch(32'h100, 1'b1, 32'h80, 1'b1, 32'h90);
    redir("tgtmiss", 1'b1, 32'h80);
    @(negedge clk); idle();
    lookup("wnt2wt", 32'h100, 1'b1, 32'h80);
    counts("tgtmiss", 9, 5);

    // Aliasing: 0x140 shares index 0 with 0x100.
    @(negedge clk);
    branch(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    redir("alias", 1'b1, 32'h200);
    @(negedge clk); idle();
    lookup("alias_old", 32'h100, 1'b0, 32'h104);
    lookup("alias_new", 32'h140, 1'b1, 32'h200);
    @(negedge clk);
    branch(32'h180, 1'b0, 32'h0, 1'b0, 32'h184);
    redir("miss_nt", 1'b0, 32'h0);
    @(negedge clk); idle();
    lookup("miss_nt", 32'h140, 1'b1, 32'h200);
    lookup("miss_nt2", 32'h180, 1'b0, 32'h184);
    counts("miss_nt", 11, 6);

    // Held in EX for three cycles, then released.
    @(negedge clk);
    branch(32'h20, 1'b1, 32'h300, 1'b0, 32'h24);
    ex_stall = 1'b1;
    repeat (3) begin
      redir("stall", 1'b0, 32'h0);
      @(negedge clk);
    end
    counts("stall", 11, 6);
    lookup("stall", 32'h20, 1'b0, 32'h24);
    ex_stall = 1'b0;
    redir("release", 1'b1, 32'h300);
    @(negedge clk); idle();
    lookup("release", 32'h20, 1'b1, 32'h300);
    counts("release", 12, 7);

    // Reset asserted during a mispredicting resolve.
    @(negedge clk);
    branch(32'h140, 1'b1, 32'h400, 1'b0, 32'h144);
    redir("prerst", 1'b1, 32'h400);
    rst_n = 1'b0;
    redir("midrst", 1'b0, 32'h0);
    lookup("midrst", 32'h140, 1'b0, 32'h144);
    counts("midrst", 0, 0);
    @(negedge clk); idle();
    rst_n = 1'b1;
    @(negedge clk);
    counts("postrst", 0, 0);
    lookup("postrst", 32'h20, 1'b0, 32'h24);
    lookup("postrst2", 32'h140, 1'b0, 32'h144);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Branch prediction and control-hazard controller for the pipelined RV32 core. It holds a direct-mapped branch target buffer with 2-bit saturating counters and supplies a predicted next PC to IF. It resolves each conditional branch in EX against the branch decision and issues the redirect and pipeline flushes on a misprediction. It also keeps branch/mispredict statistics counters.

## Interface
Parameters:
- IDX_BITS, 4, log2 of BTB entries (16); index = pc[IDX_BITS+1:2], tag = pc[31:IDX_BITS+2]
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  32  PC being fetched
- pred_taken  out  1  IF prediction; comb: entry valid & tag hit & ctr[1]
- pred_target  out  32  stored target on hit, else if_pc+4
- ex_branch  in  1  conditional branch instruction valid in EX
- ex_stall  in  1  EX held this cycle; suppresses resolution and updates
- ex_pc  in  32  PC of branch in EX
- ex_taken  in  1  actual direction from branch decision logic
- ex_target  in  32  computed branch target
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- ex_pred_target  in  32  predicted next PC carried down the pipe
- redirect  out  1  comb: mispredict resolved this cycle
- redirect_pc  out  32  ex_target if ex_taken, else ex_pc+4
- flush_if_id  out  1  equals redirect
- flush_id_ex  out  1  equals redirect
- branch_count  out  CNT_W  resolved branches since reset
- mispredict_count  out  CNT_W  redirects since reset

## Operation
- Resolve condition: ex_branch & ~ex_stall.
- Mispredict: resolve & (ex_taken != ex_pred_taken, or ex_taken & ex_pred_target != ex_target).
- Entry fields: valid, tag, target[31:0], ctr[1:0]. Encodings SNT=00, WNT=01, WT=10, ST=11.
- Update on resolve, at index/tag of ex_pc:
  - hit & taken: ctr saturating +1 (11 stays 11); target <= ex_target.
  - hit & not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - miss & taken: allocate (overwrite): valid=1, tag, target=ex_target, ctr=WT.
  - miss & not taken: no write.
- Statistics:
  - branch_count +1 on every resolve.
  - mispredict_count +1 on every redirect.
  - Both wrap modulo 2^CNT_W.
- Non-branch instructions and stalled cycles never modify state, and redirect=0.

## Timing
- Lookup is combinational: pred_taken/pred_target valid in the same cycle as if_pc.
- Redirect and flushes are combinational from EX inputs in the resolve cycle. Fetch uses redirect_pc at the next edge.
- Table writes take effect at the clock edge ending the resolve cycle, so the next cycle's lookup sees them.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents (no bypass).
- Reset (async, any time including mid-resolve):
  - all valid=0, all ctr=WNT, targets=0, both counters=0.
  - redirect/flush=0, pred_taken=0, pred_target=if_pc+4 while rst_n low.
- ex_stall high with ex_branch high: no update and no redirect. Resolution happens in the first unstalled cycle.

## Structure
- Counter encodings (SNT/WNT/WT/ST) and the allocation value go in `defines.v` as shared constants.
- One sub-module: `sat_ctr2`, combinational 2-bit saturating up/down next-state, instantiated once on the write path.
- The BTB is a register array (2^IDX_BITS entries) with asynchronous read and synchronous write, reset via rst_n.

## Test plan
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104. Both counters 0.
- Branch at 0x100 resolved taken to 0x80 with ex_pred_taken=0 -> redirect=1, redirect_pc=0x80, flushes=1. Next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x80 (ctr=WT). mispredict_count=1.
- Same branch correctly predicted taken twice -> no redirect, ctr=ST. Then resolved not taken with ex_pred_taken=1 -> redirect_pc=0x104, ctr=WT, prediction still taken.
- Aliasing: 0x100 allocated, then 0x140 (same index, IDX_BITS=4) resolved taken -> entry replaced. Lookup 0x100 misses (pred_target=0x104).
- ex_branch=1 with ex_stall=1 for 3 cycles, then released -> exactly one update, branch_count +1, redirect only in the release cycle.
- Assert rst_n low in the same cycle as a mispredicting resolve -> redirect=0, table cleared, counters 0 after release.
